// File: rtl/hydra_video_pkg.sv
// Shared types and constants for the video test-pattern path.
// Imported by the pattern generator and its helper blocks.
package hydra_video_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } pg_state_e;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_XOR   = 2'd3
    } pattern_e;

    localparam logic [23:0] SOLID_COLOR = 24'h0000FF;

    // Each bar index bit drives one full colour channel: {R, G, B}.
    function automatic logic [23:0] bar_color(input logic [2:0] b);
        return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

endpackage

// File: rtl/axi_stream_pattern_gen_if.sv
// AXI-Stream video beat bundle (pixel, valid, end-of-line, start-of-frame, ready).
interface axi_stream_pattern_gen_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axi_stream_pattern_gen_xy_counter.sv
// Raster x/y position counter; x runs fastest, both wrap at the frame end.
module video_xy_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             last_x,
    output logic             last_xy,
    output logic             first_xy
);
    logic last_y;

    assign last_x   = (x == CNT_W'(H_ACTIVE - 1));
    assign last_y   = (y == CNT_W'(V_ACTIVE - 1));
    assign last_xy  = last_x && last_y;
    assign first_xy = (x == '0) && (y == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_x) begin
                x <= '0;
                y <= last_y ? '0 : y + CNT_W'(1);
            end else begin
                x <= x + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_stream_pattern_gen.sv
// AXI-Stream video test-pattern source: H_ACTIVE x V_ACTIVE frames with SOF on tuser,
// EOL on tlast, optional idle gap between frames and a completed-frame counter.
module axi_stream_pattern_gen
    import hydra_video_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CNT_W      = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                pattern_sel,
    input  logic [15:0]               frame_gap,
    axi_stream_pattern_gen_if.master  m_axis,
    output logic [31:0]               frames_sent,
    output logic                      busy
);
    localparam logic [CNT_W+2:0] H_DIV = (CNT_W+3)'(H_ACTIVE);

    pg_state_e             state, state_d;
    pattern_e              pat_q, pat_cur;
    logic [7:0]            f_q, f_start, f_cur;
    logic [15:0]           gap_cnt;
    logic [31:0]           frames_cnt;
    logic [DATA_WIDTH-1:0] tdata_q, pixel;
    logic                  tvalid_q, tlast_q, tuser_q, eof_q;
    logic                  tready;
    logic                  load, start_new, ctr_clear, frame_done;
    logic [CNT_W-1:0]      x, y;
    logic [7:0]            x8, y8;
    logic                  last_x, last_xy, first_xy;
    logic [2:0]            bar_idx;

    assign tready = m_axis.tready;

    // Counters always point at the next pixel to be loaded into the output register.
    video_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CNT_W    (CNT_W)
    ) u_xy (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ctr_clear),
        .advance  (load),
        .x        (x),
        .y        (y),
        .last_x   (last_x),
        .last_xy  (last_xy),
        .first_xy (first_xy)
    );

    assign frame_done = (state == ACTIVE) && tvalid_q && eof_q && tready;
    assign ctr_clear  = (state == IDLE) && enable;
    assign f_start    = frame_done ? 8'(frames_cnt + 32'd1) : 8'(frames_cnt);

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        start_new = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (tvalid_q && eof_q) begin
                    if (tready) begin
                        if (frame_gap != 16'd0) begin
                            state_d = GAP;
                        end else if (enable) begin
                            load      = 1'b1;
                            start_new = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (!tvalid_q || tready) begin
                    load = 1'b1;
                end
            end
            GAP: begin
                // SOF is loaded on the last gap cycle so the idle run is exactly frame_gap long.
                if (gap_cnt == 16'd1) begin
                    if (enable) begin
                        state_d   = ACTIVE;
                        load      = 1'b1;
                        start_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A frame started without passing through IDLE uses the live selection for its SOF pixel.
    assign pat_cur = start_new ? pattern_e'(pattern_sel) : pat_q;
    assign f_cur   = start_new ? f_start : f_q;
    assign x8      = 8'(x);
    assign y8      = 8'(y);
    assign bar_idx = 3'(({3'b000, x} << 3) / H_DIV);

    always_comb begin
        pixel = '0;
        case (pat_cur)
            PAT_SOLID: pixel = SOLID_COLOR;
            PAT_RAMP:  pixel = {x8, x8, x8};
            PAT_BARS:  pixel = bar_color(bar_idx);
            PAT_XOR:   pixel = {x8 ^ y8, y8, f_cur};
            default:   pixel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pat_q      <= PAT_SOLID;
            f_q        <= '0;
            gap_cnt    <= '0;
            frames_cnt <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state <= state_d;

            if (frame_done) begin
                frames_cnt <= frames_cnt + 32'd1;
                gap_cnt    <= frame_gap;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end

            if (ctr_clear) begin
                pat_q <= pattern_e'(pattern_sel);
                f_q   <= 8'(frames_cnt);
            end else if (start_new) begin
                pat_q <= pattern_e'(pattern_sel);
                f_q   <= f_start;
            end

            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= pixel;
                tlast_q  <= last_x;
                tuser_q  <= first_xy;
                eof_q    <= last_xy;
            end else if (tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign frames_sent   = frames_cnt;
    assign busy          = (state != IDLE);

endmodule

// File: doc/axi_stream_pattern_gen.md
# axi_stream_pattern_gen

Parameterised AXI-Stream video test-pattern source for the HDMI/TMDS path. Generates frames of `H_ACTIVE × V_ACTIVE` pixels, marking start-of-frame on `tuser` and end-of-line on `tlast`. It sits directly upstream of the stream sink / TMDS encoder stub and supplies known, reproducible pixel data for frame counting and CRC checks.

## Interface
- `DATA_WIDTH`, 24: pixel width, packed {R[23:16], G[15:8], B[7:0]}; only 24 is supported.
- `H_ACTIVE`, 640: pixels per line, ≥ 2.
- `V_ACTIVE`, 480: lines per frame, ≥ 1.
- `CNT_W`, 12: width of the x/y counters; must satisfy 2^CNT_W > max(H_ACTIVE, V_ACTIVE).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  level; when high, frames are generated back-to-back, separated by the gap.
- `pattern_sel`  in  2  0 = solid, 1 = ramp, 2 = bars, 3 = xor; sampled at frame start only.
- `frame_gap`  in  16  idle cycles between frames; sampled when the last pixel of a frame is accepted.
- `m_axis_tdata`  out  DATA_WIDTH  pixel.
- `m_axis_tvalid`  out  1  pixel valid.
- `m_axis_tlast`  out  1  last pixel of a line (x == H_ACTIVE-1).
- `m_axis_tuser`  out  1  first pixel of a frame (x == 0, y == 0).
- `m_axis_tready`  in  1  downstream ready.
- `frames_sent`  out  32  count of completed frames (last pixel of a frame accepted); wraps.
- `busy`  out  1  high in ACTIVE or GAP.

## Operation
- FSM states: IDLE, ACTIVE, GAP. The state encoding comes from the package.
- **IDLE**
  - With `enable`=1, latch `pattern_sel` into `pat_q`.
  - Clear x, y and move to ACTIVE.
- **ACTIVE**
  - Outputs are registered; tvalid=1.
  - On handshake (tvalid & tready), x increments.
  - At x == H_ACTIVE-1, x wraps to 0 and y increments.
  - At x == H_ACTIVE-1 and y == V_ACTIVE-1, `frames_sent`++ and `gap_cnt` ← `frame_gap`.
    - `frame_gap` == 0: go to ACTIVE with a new frame if `enable`=1, else IDLE.
    - `frame_gap` > 0: go to GAP.
  - Deasserting `enable` mid-frame has no effect until the frame ends. Frames are never truncated.
- **GAP**
  - tvalid=0; `gap_cnt` decrements.
  - When `gap_cnt` == 1, the next state is ACTIVE if `enable`=1, else IDLE.
- **Patterns** (f = low 8 bits of `frames_sent` latched at SOF):
  - 0 solid: 24'h0000FF.
  - 1 ramp: {x[7:0], x[7:0], x[7:0]}.
  - 2 bars: bar index b = (x·8)/H_ACTIVE, range 0..7, using CNT_W+3-bit intermediate arithmetic. Pixel = {b[2]?FF:00, b[1]?FF:00, b[0]?FF:00}.
  - 3 xor: {x[7:0]^y[7:0], y[7:0], f}.
- **AXI-Stream rules**
  - Once asserted, tvalid stays high until the handshake completes.
  - tdata, tlast and tuser stay stable while tvalid=1 and tready=0.
  - No combinational path from tready to tvalid.

## Timing
- Reset values: tvalid=0, tdata=0, tlast=0, tuser=0, `frames_sent`=0, busy=0, state=IDLE, x=y=0.
- Latency from `enable` rising in IDLE to the first tvalid: 2 cycles. Cycle 1 latches the pattern; cycle 2 presents the SOF pixel registered.
- With tready held at 1, throughput is 1 pixel/cycle, including across line boundaries.
- Frame-to-frame spacing at full rate: H_ACTIVE·V_ACTIVE + `frame_gap` cycles.
- `frames_sent` updates in the cycle after the final handshake.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately. The partial frame is not counted.
- With V_ACTIVE=1, every tlast is also the end of the frame. tuser and tlast never coincide, because H_ACTIVE ≥ 2.

## Structure
- Package `hydra_video_pkg`:
  - `pg_state_e` (IDLE/ACTIVE/GAP).
  - `pattern_e` (PAT_SOLID/PAT_RAMP/PAT_BARS/PAT_XOR).
  - The `SOLID_COLOR` constant.
- Sub-module `video_xy_counter`: x/y counters with an advance input, providing `last_x`, `last_xy` and `first_xy` flags.
- The pattern mux and output register stage stay in the top level.

## Test plan
- **Basic frame:** H=4, V=2, pattern 1, gap 0, tready=1.
  - 8 beats: tdata 000000, 010101, 020202, 030303, then repeated.
  - tuser on beat 0; tlast on beats 3 and 7.
  - `frames_sent` reaches 1.
- **Backpressure:** random tready at 50% duty, H=4, V=2.
  - tdata/tlast/tuser held stable while stalled.
  - Sink sees an identical 8-beat sequence; tvalid is never dropped before the handshake.
- **Gap and disable:** gap=5.
  - Exactly 5 tvalid=0 cycles between frames.
  - Dropping `enable` mid-frame 2 still completes frame 2, then IDLE with busy=0.
- **Bars:** H=16, V=1, pattern 2.
  - Pixel pairs step 000000, 0000FF, 00FF00, 00FFFF … FFFFFF.
- **Sink coupling:** pattern 0, H=4, V=2, connected to the stream sink stub.
  - Beat count 8, tlast count 2.
  - CRC per frame is 0, because 0000FF XORed an even number of times per line cancels.
- **Reset mid-frame:** assert rst_n low at beat 3.
  - All outputs are 0 and `frames_sent` is 0.
  - After release with `enable`=1, a full frame starts with tuser 2 cycles later.
